// File: rtl/csr_avmm_master.sv
// Avalon-MM master issuing single 32-bit CSR reads/writes from a valid/ready
// command port, with one outstanding transaction and a hung-slave timeout.
module csr_avmm_master #(
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              avm_waitrequest,
    output logic [15:0]       stat_timeouts,
    output logic [15:0]       stat_stray_rdv
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RD,
        ST_RESP
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic              read_reg, read_next;
    logic              write_reg, write_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [31:0]       rsp_data_reg, rsp_data_next;
    logic              rsp_timeout_reg, rsp_timeout_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [15:0]       stat_tmo_reg, stat_tmo_next;
    logic [15:0]       stat_rdv_reg, stat_rdv_next;
    logic              expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            read_reg        <= 1'b0;
            write_reg       <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_data_reg    <= '0;
            rsp_timeout_reg <= 1'b0;
            cnt_reg         <= '0;
            stat_tmo_reg    <= '0;
            stat_rdv_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            wdata_reg       <= wdata_next;
            read_reg        <= read_next;
            write_reg       <= write_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_data_reg    <= rsp_data_next;
            rsp_timeout_reg <= rsp_timeout_next;
            cnt_reg         <= cnt_next;
            stat_tmo_reg    <= stat_tmo_next;
            stat_rdv_reg    <= stat_rdv_next;
        end
    end

    // The counter saturates at its last value, so a read accepted exactly at
    // expiry still times out in WAIT_RD unless data arrives on the next cycle.
    assign expired = (cnt_reg == CNT_LAST);

    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        wdata_next       = wdata_reg;
        read_next        = read_reg;
        write_next       = write_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_data_next    = rsp_data_reg;
        rsp_timeout_next = rsp_timeout_reg;
        cnt_next         = cnt_reg;
        stat_tmo_next    = stat_tmo_reg;
        stat_rdv_next    = stat_rdv_reg;

        // Read data arriving with no read in flight (e.g. late after a timeout) is dropped.
        if (avm_readdatavalid && (state_reg != ST_WAIT_RD) && (stat_rdv_reg != 16'hFFFF)) begin
            stat_rdv_next = stat_rdv_reg + 16'd1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_next  = cmd_addr;
                    wdata_next = cmd_wdata;
                    read_next  = ~cmd_write;
                    write_next = cmd_write;
                    cnt_next   = '0;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_next = expired ? cnt_reg : cnt_reg + 1'b1;
                if (!avm_waitrequest) begin
                    read_next  = 1'b0;
                    write_next = 1'b0;
                    if (write_reg) begin
                        rsp_data_next    = '0;
                        rsp_timeout_next = 1'b0;
                        rsp_valid_next   = 1'b1;
                        state_next       = ST_RESP;
                    end else begin
                        state_next = ST_WAIT_RD;
                    end
                end else if (expired) begin
                    read_next        = 1'b0;
                    write_next       = 1'b0;
                    rsp_data_next    = TIMEOUT_DATA;
                    rsp_timeout_next = 1'b1;
                    rsp_valid_next   = 1'b1;
                    if (stat_tmo_reg != 16'hFFFF) stat_tmo_next = stat_tmo_reg + 16'd1;
                    state_next       = ST_RESP;
                end
            end
            ST_WAIT_RD: begin
                cnt_next = expired ? cnt_reg : cnt_reg + 1'b1;
                if (avm_readdatavalid) begin
                    rsp_data_next    = avm_readdata;
                    rsp_timeout_next = 1'b0;
                    rsp_valid_next   = 1'b1;
                    state_next       = ST_RESP;
                end else if (expired) begin
                    rsp_data_next    = TIMEOUT_DATA;
                    rsp_timeout_next = 1'b1;
                    rsp_valid_next   = 1'b1;
                    if (stat_tmo_reg != 16'hFFFF) stat_tmo_next = stat_tmo_reg + 16'd1;
                    state_next       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready      = (state_reg == ST_IDLE);
    assign rsp_valid      = rsp_valid_reg;
    assign rsp_data       = rsp_data_reg;
    assign rsp_timeout    = rsp_timeout_reg;
    assign avm_address    = addr_reg;
    assign avm_read       = read_reg;
    assign avm_write      = write_reg;
    assign avm_writedata  = wdata_reg;
    assign avm_byteenable = 4'hF;
    assign stat_timeouts  = stat_tmo_reg;
    assign stat_stray_rdv = stat_rdv_reg;

endmodule
